// File: rtl/moore_seq_generator_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | moore_seq_generator_if                                                   |
// | Control and serial-output bundle of the pattern transmitter.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface moore_seq_generator_if #(
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
);
    logic             start_i;
    logic             stop_i;
    logic [CNT_W-1:0] repeat_cnt_i;
    logic [GAP_W-1:0] gap_i;
    logic             data_o;
    logic             valid_o;
    logic             frame_start_o;
    logic             busy_o;
    logic             done_o;

    modport master (
        output start_i, stop_i, repeat_cnt_i, gap_i,
        input  data_o, valid_o, frame_start_o, busy_o, done_o
    );

    modport slave (
        input  start_i, stop_i, repeat_cnt_i, gap_i,
        output data_o, valid_o, frame_start_o, busy_o, done_o
    );
endinterface
`default_nettype wire

// File: rtl/moore_seq_generator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | moore_seq_generator                                                      |
// | Sends PATTERN MSB first for a burst of frames with optional idle gaps.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module moore_seq_generator #(
    parameter int                 PAT_W   = 5,
    parameter logic [PAT_W-1:0]   PATTERN = 5'b10011,
    parameter int                 CNT_W   = 8,
    parameter int                 GAP_W   = 4
) (
    input  wire logic                clk,
    input  wire logic                rst_n,
    moore_seq_generator_if.slave     bus
);
    localparam int              BIT_W    = $clog2(PAT_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PAT_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q;
    logic [PAT_W-1:0]   shreg_q;
    logic [BIT_W-1:0]   bit_cnt_q;
    logic [CNT_W-1:0]   frame_cnt_q;
    logic [GAP_W-1:0]   gap_cnt_q;
    logic [GAP_W-1:0]   gap_len_q;
    logic               stop_q;
    logic               data_q;
    logic               valid_q;
    logic               frame_start_q;
    logic               busy_q;
    logic               done_q;

    logic               stop_d;
    logic               last_frame_d;

    // A stop arriving on the deciding edge counts just like an earlier one.
    assign stop_d       = stop_q | bus.stop_i;
    assign last_frame_d = (frame_cnt_q == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            shreg_q       <= '0;
            bit_cnt_q     <= '0;
            frame_cnt_q   <= '0;
            gap_cnt_q     <= '0;
            gap_len_q     <= '0;
            stop_q        <= 1'b0;
            data_q        <= 1'b0;
            valid_q       <= 1'b0;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            frame_start_q <= 1'b0;
            done_q        <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    stop_q  <= 1'b0;
                    data_q  <= 1'b0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    if (bus.start_i) begin
                        gap_len_q   <= bus.gap_i;
                        frame_cnt_q <= bus.repeat_cnt_i;
                        if (bus.repeat_cnt_i == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q       <= S_SEND;
                            bit_cnt_q     <= '0;
                            shreg_q       <= {PATTERN[PAT_W-2:0], 1'b0};
                            data_q        <= PATTERN[PAT_W-1];
                            valid_q       <= 1'b1;
                            frame_start_q <= 1'b1;
                            busy_q        <= 1'b1;
                        end
                    end
                end

                S_SEND: begin
                    if (bus.stop_i) stop_q <= 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        if (!last_frame_d && !stop_d) begin
                            frame_cnt_q <= frame_cnt_q - 1'b1;
                            if (gap_len_q != '0) begin
                                state_q   <= S_GAP;
                                gap_cnt_q <= gap_len_q - 1'b1;
                                data_q    <= 1'b0;
                                valid_q   <= 1'b0;
                            end else begin
                                bit_cnt_q     <= '0;
                                shreg_q       <= {PATTERN[PAT_W-2:0], 1'b0};
                                data_q        <= PATTERN[PAT_W-1];
                                frame_start_q <= 1'b1;
                            end
                        end else begin
                            state_q <= S_DONE;
                            data_q  <= 1'b0;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        data_q    <= shreg_q[PAT_W-1];
                        shreg_q   <= {shreg_q[PAT_W-2:0], 1'b0};
                    end
                end

                S_GAP: begin
                    if (bus.stop_i) stop_q <= 1'b1;
                    if (stop_d) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (gap_cnt_q == '0) begin
                        state_q       <= S_SEND;
                        bit_cnt_q     <= '0;
                        shreg_q       <= {PATTERN[PAT_W-2:0], 1'b0};
                        data_q        <= PATTERN[PAT_W-1];
                        valid_q       <= 1'b1;
                        frame_start_q <= 1'b1;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 1'b1;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    stop_q  <= 1'b0;
                    data_q  <= 1'b0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_o        = data_q;
    assign bus.valid_o       = valid_q;
    assign bus.frame_start_o = frame_start_q;
    assign bus.busy_o        = busy_q;
    assign bus.done_o        = done_q;
endmodule
`default_nettype wire

// File: tb/tb_moore_seq_generator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_moore_seq_generator                                                   |
// | Randomized bench with a frame-level reference model of the transmitter.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_moore_seq_generator;
    localparam int             PAT_W   = 5;
    localparam logic [PAT_W-1:0] PATTERN = 5'b10011;
    localparam int             CNT_W   = 8;
    localparam int             GAP_W   = 4;
    localparam int             MAXC    = 128;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    moore_seq_generator_if #(.CNT_W(CNT_W), .GAP_W(GAP_W)) bus ();

    moore_seq_generator #(
        .PAT_W(PAT_W), .PATTERN(PATTERN), .CNT_W(CNT_W), .GAP_W(GAP_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    // Per-cycle output vector: {data, valid, frame_start, busy, done}
    logic [4:0] exp_v [MAXC];
    logic [4:0] obs_v [MAXC];
    int         exp_len;

    function automatic logic [4:0] outs();
        return {bus.data_o, bus.valid_o, bus.frame_start_o, bus.busy_o, bus.done_o};
    endfunction

    // Expected trace starting with the cycle after the accepting edge.
    // s = cycle index during which stop is held high (-1: never).
    function automatic void build_expected(int n, int g, int s);
        logic [PAT_W-1:0] pat = PATTERN;
        int  t = 0;
        bit  stopped = 0;
        exp_len = 0;
        for (int f = 0; f < n; f++) begin
            for (int b = 0; b < PAT_W; b++) begin
                exp_v[exp_len] = {pat[PAT_W-1-b], 1'b1, (b == 0), 1'b1, 1'b0};
                exp_len++;
                if (t == s) stopped = 1;
                t++;
            end
            if (f == n - 1 || stopped) break;
            for (int j = 0; j < g && !stopped; j++) begin
                exp_v[exp_len] = 5'b00010;
                exp_len++;
                if (t == s) stopped = 1;
                t++;
            end
            if (stopped) break;
        end
        exp_v[exp_len] = 5'b00001; exp_len++;
        exp_v[exp_len] = 5'b00000; exp_len++;
        exp_v[exp_len] = 5'b00000; exp_len++;
    endfunction

    // Drives one burst and records outputs; sp = cycle to pulse a stray start.
    task automatic capture(int n, int g, int s, int sp);
        build_expected(n, g, s);
        @(negedge clk);
        bus.start_i      = 1'b1;
        bus.repeat_cnt_i = CNT_W'(n);
        bus.gap_i        = GAP_W'(g);
        @(negedge clk);
        bus.start_i      = 1'b0;
        bus.repeat_cnt_i = CNT_W'($urandom);
        bus.gap_i        = GAP_W'($urandom);
        for (int t = 0; t < exp_len; t++) begin
            obs_v[t]    = outs();
            bus.stop_i  = (t == s);
            bus.start_i = (t == sp);
            @(negedge clk);
        end
        bus.stop_i  = 1'b0;
        bus.start_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            n_vec++;
            if (outs() !== 5'b00000) begin
                n_err++;
                $display("FAIL reset_idle cyc=%0d got=%b exp=%b", t, outs(), 5'b00000);
            end
        end
    endtask

    task automatic test_single_frame();
        capture(1, 0, -1, -1);
        for (int t = 0; t < exp_len; t++) begin
            n_vec++;
            if (obs_v[t] !== exp_v[t]) begin
                n_err++;
                $display("FAIL single_frame cyc=%0d got=%b exp=%b", t, obs_v[t], exp_v[t]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [PAT_W-1:0] hist = '0;
        int nbits = 0;
        int hits  = 0;
        capture(3, 0, -1, -1);
        for (int t = 0; t < exp_len; t++) begin
            n_vec++;
            if (obs_v[t] !== exp_v[t]) begin
                n_err++;
                $display("FAIL back_to_back cyc=%0d got=%b exp=%b", t, obs_v[t], exp_v[t]);
            end
            if (obs_v[t][3]) begin
                hist = {hist[PAT_W-2:0], obs_v[t][4]};
                nbits++;
                if (nbits >= PAT_W && hist == PATTERN) begin
                    hits++;
                    n_vec++;
                    if (t % PAT_W != PAT_W - 1) begin
                        n_err++;
                        $display("FAIL detector_pos got_cyc=%0d exp_cyc_mod=%0d", t, PAT_W - 1);
                    end
                end
            end
        end
        n_vec++;
        if (hits != 3 || nbits != 15) begin
            n_err++;
            $display("FAIL detector_hits got=%0d/%0d exp=3/15", hits, nbits);
        end
    endtask

    task automatic test_gaps();
        int busy_cnt = 0;
        capture(2, 3, -1, -1);
        for (int t = 0; t < exp_len; t++) begin
            n_vec++;
            if (obs_v[t] !== exp_v[t]) begin
                n_err++;
                $display("FAIL gaps cyc=%0d got=%b exp=%b", t, obs_v[t], exp_v[t]);
            end
            if (obs_v[t][1]) busy_cnt++;
        end
        n_vec++;
        if (busy_cnt != 13 || obs_v[13][0] !== 1'b1) begin
            n_err++;
            $display("FAIL gaps_busy got=%0d done13=%b exp=13 done13=1", busy_cnt, obs_v[13][0]);
        end
    endtask

    task automatic test_stop_zero();
        capture(5, 0, 1, -1);
        for (int t = 0; t < exp_len; t++) begin
            n_vec++;
            if (obs_v[t] !== exp_v[t]) begin
                n_err++;
                $display("FAIL stop cyc=%0d got=%b exp=%b", t, obs_v[t], exp_v[t]);
            end
        end
        capture(0, 2, -1, -1);
        for (int t = 0; t < exp_len; t++) begin
            n_vec++;
            if (obs_v[t] !== exp_v[t]) begin
                n_err++;
                $display("FAIL zero_count cyc=%0d got=%b exp=%b", t, obs_v[t], exp_v[t]);
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        bus.start_i      = 1'b1;
        bus.repeat_cnt_i = CNT_W'(2);
        bus.gap_i        = '0;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (outs() !== 5'b00000) begin
            n_err++;
            $display("FAIL async_reset got=%b exp=%b", outs(), 5'b00000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        capture(1, 0, -1, -1);
        for (int t = 0; t < exp_len; t++) begin
            n_vec++;
            if (obs_v[t] !== exp_v[t]) begin
                n_err++;
                $display("FAIL post_reset cyc=%0d got=%b exp=%b", t, obs_v[t], exp_v[t]);
            end
        end
    endtask

    task automatic test_ignored_start();
        capture(2, 2, -1, 3);
        for (int t = 0; t < exp_len; t++) begin
            n_vec++;
            if (obs_v[t] !== exp_v[t]) begin
                n_err++;
                $display("FAIL ignored_start cyc=%0d got=%b exp=%b", t, obs_v[t], exp_v[t]);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 12; it++) begin
            int n = int'($urandom_range(0, 5));
            int g = int'($urandom_range(0, 3));
            int s = -1;
            if (n > 0 && $urandom_range(0, 1) == 1)
                s = int'($urandom_range(0, n * PAT_W + (n - 1) * g - 1));
            capture(n, g, s, -1);
            for (int t = 0; t < exp_len; t++) begin
                n_vec++;
                if (obs_v[t] !== exp_v[t]) begin
                    n_err++;
                    $display("FAIL random it=%0d n=%0d g=%0d s=%0d cyc=%0d got=%b exp=%b",
                             it, n, g, s, t, obs_v[t], exp_v[t]);
                end
            end
        end
    endtask

    initial begin
        bus.start_i      = 1'b0;
        bus.stop_i       = 1'b0;
        bus.repeat_cnt_i = '0;
        bus.gap_i        = '0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_gaps();
        test_stop_zero();
        test_async_reset();
        test_ignored_start();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
